// File: rtl/decode_issue_pkg.sv
// Shared opcode/funct constants and the decoded-instruction record.
// XLEN is the operand width carried by decoded_t; decode_issue's WIDTH is
// expected to equal it.
package decode_issue_pkg;

  localparam int XLEN  = 32;
  localparam int REGAW = 5;

  // Major opcodes handled by this stage.
  localparam logic [6:0] RTYPEOP = 7'b0110011;
  localparam logic [6:0] ITYPEOP = 7'b0010011;

  // funct3 / funct7 encodings as consumed by the execute-stage ALU.
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;  // SUB / SRA / SRAI

  typedef struct packed {
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [REGAW-1:0] rd;
    logic             reg_write;
    logic             illegal;
  } decoded_t;

  // Sign-extend a 12-bit I-type immediate to the operand width.
  function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Bundle of every decode/issue signal except clk/rst_n.
//   fetch side : in_valid, in_instr -> in_ready
//   regfile    : rs1_addr, rs2_addr -> rs1_data, rs2_data (same cycle)
//   execute    : out_valid, op1, op2, opcode, funct3, funct7, rd,
//                reg_write, illegal <- out_ready
//   control    : wb_valid, wb_rd (writeback), flush (synchronous squash)
// slave  = the decode/issue stage, master = its environment.
interface decode_issue_if #(parameter int WIDTH = 32);

  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [4:0]       rd;
  logic             reg_write;
  logic             illegal;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             flush;

  modport slave (
    input  in_valid, in_instr, rs1_data, rs2_data, out_ready,
           wb_valid, wb_rd, flush,
    output in_ready, rs1_addr, rs2_addr, out_valid, op1, op2, opcode,
           funct3, funct7, rd, reg_write, illegal
  );

  modport master (
    output in_valid, in_instr, rs1_data, rs2_data, out_ready,
           wb_valid, wb_rd, flush,
    input  in_ready, rs1_addr, rs2_addr, out_valid, op1, op2, opcode,
           funct3, funct7, rd, reg_write, illegal
  );

endinterface

// File: rtl/decode_issue_scoreboard.sv
// Register busy scoreboard for the issue stage.
//   rs1, rs2, rd : fields of the instruction asking to issue
//   check_en     : instruction is a supported type (illegal ones skip checks)
//   use_rs2      : instruction reads rs2 (R-type)
//   set_en/rd    : an issued instruction will write set_rd
//   clr_en/rd    : writeback of clr_rd completed
//   flush        : squash all outstanding writes
//   hazard       : RAW on rs1/rs2 or WAW on rd against registered busy bits
module issue_scoreboard #(
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic          check_en,
  input  logic          use_rs2,
  input  logic          set_en,
  input  logic [AW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic          flush,
  output logic          hazard
);

  // Bit 0 is never set, so x0 reads and writes never stall.
  logic [NREGS-1:0] busy;

  // NOTE: busy is a small flop vector rather than a RAM, so it is reset: a
  // stale bit left over from before reset would stall issue indefinitely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments; the set below is the last write to
      // the same bit, so a simultaneous set and clear leaves it set.
      if (clr_en) busy[clr_rd] <= 1'b0;
      if (set_en && (set_rd != '0)) busy[set_rd] <= 1'b1;
    end
  end

  // No writeback bypass: a stalled instruction issues the cycle after its
  // busy bit has actually cleared.
  assign hazard = check_en &
                  (busy[rs1] | (use_rs2 & busy[rs2]) | ((rd != '0) & busy[rd]));

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage feeding the execute-stage ALU.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decode_issue_if.slave (fetch handshake, regfile read ports,
//                one-entry issue register toward execute, writeback, flush)
// R-type and I-type instructions are decoded into ALU operands and held in a
// one-entry output register; a scoreboard stalls RAW/WAW hazards until
// writeback. Unsupported opcodes issue with illegal=1 and no side effects.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int NREGS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_issue_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [31:0] instr;
  logic        is_rtype;
  logic        is_itype;
  logic        hazard;
  logic        fire;
  logic        slot_valid;
  decoded_t    dec;
  decoded_t    slot;

  assign instr        = bus.in_instr;
  assign is_rtype     = (instr[6:0] == RTYPEOP);
  assign is_itype     = (instr[6:0] == ITYPEOP);
  assign bus.rs1_addr = instr[19:15];
  assign bus.rs2_addr = instr[24:20];

  // NOTE: the whole record gets a default before the case so that no path
  // leaves a field unassigned, which would otherwise infer a latch.
  always_comb begin
    dec        = '0;
    dec.opcode = instr[6:0];
    dec.funct3 = instr[14:12];
    dec.funct7 = instr[31:25];
    dec.rd     = instr[11:7];
    case (instr[6:0])
      RTYPEOP: begin
        dec.op1       = bus.rs1_data;
        dec.op2       = bus.rs2_data;
        dec.reg_write = (instr[11:7] != 5'd0);
      end
      ITYPEOP: begin
        // Shift-immediates use op2[4:0] as shamt; funct7 separates SRLI/SRAI.
        dec.op1       = bus.rs1_data;
        dec.op2       = sext_imm12(instr[31:20]);
        dec.reg_write = (instr[11:7] != 5'd0);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  issue_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (instr[15 +: AW]),
    .rs2      (instr[20 +: AW]),
    .rd       (instr[7 +: AW]),
    .check_en (is_rtype | is_itype),
    .use_rs2  (is_rtype),
    .set_en   (fire & dec.reg_write),
    .set_rd   (instr[7 +: AW]),
    .clr_en   (bus.wb_valid),
    .clr_rd   (bus.wb_rd[AW-1:0]),
    .flush    (bus.flush),
    .hazard   (hazard)
  );

  assign bus.in_ready = ~bus.flush & (~slot_valid | bus.out_ready) & ~hazard;
  assign fire         = bus.in_valid & bus.in_ready;

  // fire already excludes flush through in_ready, so flush only has to
  // drop the valid bit; the data fields are don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      slot       <= '0;
    end else if (bus.flush) begin
      slot_valid <= 1'b0;
    end else if (fire) begin
      slot_valid <= 1'b1;
      slot       <= dec;
    end else if (bus.out_ready) begin
      slot_valid <= 1'b0;
    end
  end

  assign bus.out_valid = slot_valid;
  assign bus.op1       = slot.op1;
  assign bus.op2       = slot.op2;
  assign bus.opcode    = slot.opcode;
  assign bus.funct3    = slot.funct3;
  assign bus.funct7    = slot.funct7;
  assign bus.rd        = slot.rd;
  assign bus.reg_write = slot.reg_write;
  assign bus.illegal   = slot.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1-2 time units after the edge.
module tb_decode_issue;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [88:0] exp_o;

  decode_issue_if #(.WIDTH(32)) bus ();

  decode_issue #(.WIDTH(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "timeout");
  end

  // {out_valid, opcode, funct3, funct7, rd, reg_write, illegal, op1, op2}
  function automatic logic [88:0] obs();
    return {bus.out_valid, bus.opcode, bus.funct3, bus.funct7, bus.rd,
            bus.reg_write, bus.illegal, bus.op1, bus.op2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] d1, input logic [31:0] d2);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.rs1_data = d1;
    bus.rs2_data = d2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.flush     = 1'b0;
    #2;
    checks++;
    if (obs() !== 89'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", obs());
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // addi x1,x0,5
  task automatic test_issue();
    bus.out_ready = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.flush     = 1'b0;
    drive(1'b1, 32'h00500093, 32'h0, 32'h0);
    #1;
    checks++;
    if ({bus.in_ready, bus.rs1_addr, bus.rs2_addr} !== {1'b1, 5'd0, 5'd5}) begin
      errors++;
      $display("FAIL issue_ready_addr: got %b/%0d/%0d want 1/0/5",
               bus.in_ready, bus.rs1_addr, bus.rs2_addr);
    end
    tick();
    bus.in_valid = 1'b0;
    exp_o = {1'b1, 7'h13, 3'd0, 7'h00, 5'd1, 1'b1, 1'b0, 32'h0, 32'h5};
    checks++;
    if (obs() !== exp_o) begin
      errors++; $display("FAIL issue_out: got %h want %h", obs(), exp_o);
    end
  endtask

  // add x2,x1,x1 stalls on busy[1] until the cycle after writeback of x1
  task automatic test_raw_stall();
    drive(1'b1, 32'h00108133, 32'h10, 32'h20);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL raw_stall_0: got %b want 0", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL raw_stall_1: got %b want 0", bus.in_ready);
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL raw_no_bypass: got %b want 0", bus.in_ready);
    end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL raw_release: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    exp_o = {1'b1, 7'h33, 3'd0, 7'h00, 5'd2, 1'b1, 1'b0, 32'h10, 32'h20};
    checks++;
    if (obs() !== exp_o) begin
      errors++; $display("FAIL raw_out: got %h want %h", obs(), exp_o);
    end
  endtask

  // srai x3,x2,4 then addi x4,x0,-1 back to back
  task automatic test_shift_imm();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd2;
    tick();
    bus.wb_valid = 1'b0;
    drive(1'b1, 32'h40415193, 32'h80000000, 32'h0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL srai_ready: got %b want 1", bus.in_ready);
    end
    tick();
    exp_o = {1'b1, 7'h13, 3'b101, 7'b0100000, 5'd3, 1'b1, 1'b0,
             32'h80000000, 32'h00000404};
    checks++;
    if (obs() !== exp_o) begin
      errors++; $display("FAIL srai_out: got %h want %h", obs(), exp_o);
    end
    drive(1'b1, 32'hFFF00213, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: got %b want 1", bus.in_ready);
    end
    tick();
    exp_o = {1'b1, 7'h13, 3'd0, 7'h7F, 5'd4, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF};
    checks++;
    if (obs() !== exp_o) begin
      errors++; $display("FAIL sext_out: got %h want %h", obs(), exp_o);
    end
  endtask

  // Output held while execute stalls; add x5,x6,x7 waits then issues
  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h007302B3, 32'h11, 32'h22);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready: got %b want 0", bus.in_ready);
    end
    exp_o = {1'b1, 7'h13, 3'd0, 7'h7F, 5'd4, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.in_ready, obs()} !== {1'b0, exp_o}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got %b/%h want 0/%h", i, bus.in_ready, obs(), exp_o);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    exp_o = {1'b1, 7'h33, 3'd0, 7'h00, 5'd5, 1'b1, 1'b0, 32'h11, 32'h22};
    checks++;
    if (obs() !== exp_o) begin
      errors++; $display("FAIL bp_out: got %h want %h", obs(), exp_o);
    end
  endtask

  // WAW stall, rd=x0 never stalls, simultaneous set and clear keeps busy
  task automatic test_waw();
    drive(1'b1, 32'h00100193, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL waw_stall: got %b want 0", bus.in_ready);
    end
    drive(1'b1, 32'h00000013, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL x0_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    exp_o = {1'b1, 7'h13, 3'd0, 7'h00, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0};
    checks++;
    if (obs() !== exp_o) begin
      errors++; $display("FAIL x0_out: got %h want %h", obs(), exp_o);
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    tick();
    drive(1'b1, 32'h00100293, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL setclr_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.wb_valid = 1'b0;
    drive(1'b1, 32'h00028313, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL set_wins: got %b want 0", bus.in_ready);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_illegal_flush();
    drive(1'b1, 32'h00500093, 32'h0, 32'h0);
    tick();
    drive(1'b1, 32'h00000003, 32'hDEADBEEF, 32'hCAFEF00D);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_ready: got %b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    exp_o = {1'b1, 7'h03, 3'd0, 7'h00, 5'd0, 1'b0, 1'b1, 32'h0, 32'h0};
    checks++;
    if (obs() !== exp_o) begin
      errors++; $display("FAIL illegal_out: got %h want %h", obs(), exp_o);
    end
    bus.in_instr = 32'h00108133;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL illegal_busy_kept: got %b want 0", bus.in_ready);
    end
    bus.in_instr = 32'h00000013;
    bus.flush    = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b want 0", bus.in_ready);
    end
    tick();
    bus.flush    = 1'b0;
    bus.in_instr = 32'h00108133;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_clear: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    bus.in_instr = 32'h00100193;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_clear_x3: got %b want 1", bus.in_ready);
    end
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    tick();
    bus.wb_valid = 1'b0;
    bus.in_instr = 32'h00108133;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL late_wb: got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h0, 32'h0);
    tick();
    drive(1'b1, 32'h00108133, 32'h0, 32'h0);
    tick();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset_stall: got valid=%b ready=%b want 1/0", bus.out_valid, bus.in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs(), bus.in_ready} !== {89'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got %h/%b want 0/1", obs(), bus.in_ready);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    test_issue();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_issue();
    test_raw_stall();
    test_shift_imm();
    test_backpressure();
    test_waw();
    test_illegal_flush();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage that drives the execute-stage ALU.
- Accepts fetched 32-bit RV32 instructions over a valid/ready handshake and reads source operands from the register file.
- Decodes R-type (OP) and I-type (OP-IMM) instructions into op1/op2/opcode/funct3/funct7 and a destination tag.
- Holds the result in a one-entry output register, with a scoreboard that stalls on RAW/WAW hazards until writeback.

Parameters:
- WIDTH, 32, datapath/operand width.
- NREGS, 32, architectural register count; index width is $clog2(NREGS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  32  instruction word.
- in_ready  out  1  stage accepts in_instr this cycle.
- rs1_addr  out  5  regfile read address A = in_instr[19:15] (combinational).
- rs2_addr  out  5  regfile read address B = in_instr[24:20] (combinational).
- rs1_data  in  WIDTH  regfile read data A, same cycle.
- rs2_data  in  WIDTH  regfile read data B, same cycle.
- out_valid  out  1  issued instruction valid toward execute.
- out_ready  in  1  execute consumes this cycle.
- op1  out  WIDTH  ALU operand 1.
- op2  out  WIDTH  ALU operand 2.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- rd  out  5  destination register.
- reg_write  out  1  instruction writes rd.
- illegal  out  1  unsupported opcode.
- wb_valid  in  1  writeback completes.
- wb_rd  in  5  writeback destination.
- flush  in  1  synchronous squash.

Behaviour:
- Reset (rst_n low, async): out_valid=0; op1, op2, opcode, funct3, funct7, rd, reg_write, illegal all 0; scoreboard busy[] all 0. in_ready follows its combinational equation with reset state values.
- Accept: fire = in_valid & in_ready. Output regs load on fire; out_valid=1 the next cycle. Latency is exactly 1 cycle.
- Output slot: when out_valid & out_ready and no fire, out_valid clears the next cycle. When out_valid & !out_ready, all outputs hold stable.
- in_ready = !flush & (!out_valid | out_ready) & !hazard. Full-throughput back-to-back issue is allowed when there is no hazard.
- Decode for opcode 0110011 (R-type):
  - op1 = rs1_data, op2 = rs2_data.
  - reg_write = (rd != 0).
- Decode for opcode 0010011 (I-type):
  - op1 = rs1_data.
  - op2 = sign-extend(instr[31:20]) to WIDTH. Shifts rely on op2[4:0] = shamt.
  - funct7 = instr[31:25], which distinguishes SRLI/SRAI.
  - reg_write = (rd != 0).
- Any other opcode: issued with illegal=1, reg_write=0, op1=op2=0. No scoreboard effect and no hazard check.
- Scoreboard: busy[NREGS-1:1]; x0 is never busy.
  - Hazard for R-type: busy[rs1] | busy[rs2] | busy[rd].
  - Hazard for I-type: busy[rs1] | busy[rd].
  - The busy[rd] term is the WAW check; it applies only when rd != 0.
  - Hazard is evaluated on the registered busy[] only; there is no same-cycle writeback bypass. The stalled instruction is accepted one cycle after the busy bit clears.
  - On fire with reg_write: set busy[rd] the next cycle.
  - On wb_valid: clear busy[wb_rd]. wb_rd=0, or a clear of a non-busy register, is a no-op.
  - Simultaneous set and clear of the same index: set wins.
- Flush (synchronous, priority over fire and wb):
  - Next cycle out_valid=0 and busy[] all 0.
  - in_ready=0 during the flush cycle.
  - Later writebacks from squashed work are harmless no-ops.
- Reset mid-stall or mid-backpressure: state returns immediately to reset values. The in-flight instruction is dropped.

Decomposition:
- Shared opcode/funct package holds:
  - RTYPEOP=7'b0110011, ITYPEOP=7'b0010011.
  - The funct3/funct7 constants already consumed by execute.
  - A decoded-instruction struct {op1, op2, opcode, funct3, funct7, rd, reg_write, illegal}.
- One sub-module: issue_scoreboard. It owns busy[], set/clear/flush logic, and the hazard output for given rs1/rs2/rd and use flags.

Test Plan:
1. Issue: reset, out_ready=1, in_instr=0x00500093 (addi x1,x0,5), rs1_data=0 -> next cycle out_valid=1, opcode=0010011, funct3=0, op1=0, op2=5, rd=1, reg_write=1; busy[1]=1.
2. RAW stall: after test 1, in_instr=0x00108133 (add x2,x1,x1) held valid -> in_ready=0. Pulse wb_valid with wb_rd=1 at cycle N -> accepted at cycle N+1; out shows opcode=0110011, rd=2.
3. Shift immediate: in_instr=0x40415193 (srai x3,x2,4), rs1_data=0x80000000, x2 not busy -> op2=0x00000404, funct7=0100000, funct3=101.
4. Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> all outputs constant and in_ready=0. Raise out_ready -> pending input accepted that cycle.
5. Illegal/flush: in_instr=0x00000003 -> illegal=1, reg_write=0, busy unchanged. Then assert flush with busy[1]=1 -> next cycle out_valid=0, busy all 0.
6. Async reset: drop rst_n mid-cycle during a stall -> out_valid=0 and busy cleared without waiting for a clk edge. After release, test 1 reproduces.
